// File: rtl/c157x_track_mgr.sv
// Track buffer manager: arbitrates per-slot track loads and dirty write-backs onto one
// SD block interface, and publishes track length, busy and hinit to the heads.
// state      | meaning
// IDLE / ARB | look for slots needing service / pick one round robin, latch tracks
// FLUSH_*    | write the dirty old track back (request, wait ack drop, end)
// LOAD_*     | read the requested track image (request, wait ack drop, commit)
module c157x_track_mgr #(
  parameter int NUM_SLOTS     = 2,
  parameter int TRACK_BUF_LEN = 16384,
  parameter int BLK_PER_TRK   = 32
) (
  input  logic                    sd_clk,
  input  logic                    reset,
  input  logic [NUM_SLOTS-1:0]    img_mounted,
  input  logic [NUM_SLOTS*7-1:0]  trk_req,
  input  logic [NUM_SLOTS*2-1:0]  freq,
  input  logic [NUM_SLOTS-1:0]    wgate,
  input  logic [NUM_SLOTS-1:0]    head_we,
  output logic [NUM_SLOTS-1:0]    slot_busy,
  output logic [NUM_SLOTS-1:0]    hinit,
  output logic [NUM_SLOTS*14-1:0] track_len,
  output logic [31:0]             sd_lba,
  output logic [5:0]              sd_blk_cnt,
  output logic [NUM_SLOTS-1:0]    sd_rd,
  output logic [NUM_SLOTS-1:0]    sd_wr,
  input  logic                    sd_ack,
  input  logic [13:0]             sd_buff_addr,
  input  logic [7:0]              sd_buff_dout,
  input  logic                    sd_buff_wr,
  output logic [7:0]              sd_buff_din,
  input  logic [NUM_SLOTS*8-1:0]  buf_q,
  output logic [NUM_SLOTS-1:0]    buf_sel
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [6:0]  TRK_NONE = 7'h7F;
  localparam logic [13:0] LEN_MAX  = 14'(TRACK_BUF_LEN - 2);

  typedef enum logic [2:0] {
    IDLE, ARB, FLUSH_REQ, FLUSH_ACK, FLUSH_END, LOAD_REQ, LOAD_ACK, LOAD_END
  } state_t;

  state_t state, state_nxt;

  logic [6:0]           trk_cur [NUM_SLOTS];
  logic [13:0]          len_r   [NUM_SLOTS];
  logic [13:0]          fmt_len [NUM_SLOTS];
  logic [1:0]           freq_q  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] wgate_q;
  logic [NUM_SLOTS-1:0] dirty;
  logic [NUM_SLOTS-1:0] mount_pend;
  logic [NUM_SLOTS-1:0] need;
  logic [SW-1:0]        rr, act, pick;
  logic                 pick_ok;
  logic [6:0]           old_trk, new_trk;
  logic                 abort_r, abort_now;
  logic                 in_xfer, flush_st, load_st, load_xfer;

  assign flush_st  = (state == FLUSH_REQ) || (state == FLUSH_ACK) || (state == FLUSH_END);
  assign load_st   = (state == LOAD_REQ)  || (state == LOAD_ACK)  || (state == LOAD_END);
  assign load_xfer = (state == LOAD_REQ)  || (state == LOAD_ACK);
  assign in_xfer   = flush_st || load_st;
  // A mount on the active slot poisons the transfer; it is dropped once the ack falls.
  assign abort_now = abort_r || img_mounted[act];

  always_comb begin
    need = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      need[s] = (trk_req[s*7 +: 7] != trk_cur[s]) || mount_pend[s];
  end

  always_comb begin : pick_blk
    int idx;
    idx     = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      idx = int'(rr) + i;
      if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
      if (!pick_ok && need[idx]) begin
        pick_ok = 1'b1;
        pick    = SW'(idx);
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (wgate[s]) fmt_len[s] = 14'd12500;
      else begin
        case (freq[s*2 +: 2])
          2'd0:    fmt_len[s] = 14'd6250;
          2'd1:    fmt_len[s] = 14'd6666;
          2'd2:    fmt_len[s] = 14'd7142;
          default: fmt_len[s] = 14'd7692;
        endcase
      end
    end
  end

  always_ff @(posedge sd_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|need) state_nxt = ARB;
      ARB: begin
        if (!pick_ok)
          state_nxt = IDLE;
        else if (dirty[pick] && trk_cur[pick] != TRK_NONE && !mount_pend[pick] && !img_mounted[pick])
          state_nxt = FLUSH_REQ;
        else
          state_nxt = LOAD_REQ;
      end
      FLUSH_REQ: if (sd_ack) state_nxt = FLUSH_ACK;
      FLUSH_ACK: if (!sd_ack) state_nxt = abort_now ? IDLE : FLUSH_END;
      FLUSH_END: state_nxt = abort_now ? IDLE : LOAD_REQ;
      LOAD_REQ:  if (sd_ack) state_nxt = LOAD_ACK;
      LOAD_ACK:  if (!sd_ack) state_nxt = abort_now ? IDLE : LOAD_END;
      LOAD_END:  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slot_busy   = '0;
    buf_sel     = '0;
    sd_rd       = '0;
    sd_wr       = '0;
    sd_lba      = '0;
    sd_buff_din = '0;
    sd_blk_cnt  = reset ? 6'd0 : 6'(BLK_PER_TRK - 1);
    if (state == ARB && pick_ok) slot_busy[pick] = 1'b1;
    if (in_xfer) begin
      slot_busy[act] = 1'b1;
      buf_sel[act]   = 1'b1;
    end
    if (!reset) begin
      sd_rd[act] = (state == LOAD_REQ);
      sd_wr[act] = (state == FLUSH_REQ);
    end
    if (flush_st)     sd_lba = 32'(old_trk) * 32'(BLK_PER_TRK);
    else if (load_st) sd_lba = 32'(new_trk) * 32'(BLK_PER_TRK);
    // Write-back image: rebuilt header, slot RAM data, 0xFF beyond the track end.
    if (flush_st) begin
      if (sd_buff_addr == 14'd0)
        sd_buff_din = len_r[act][7:0];
      else if (sd_buff_addr == 14'd1)
        sd_buff_din = {2'b00, len_r[act][13:8]};
      else if ({1'b0, sd_buff_addr} > ({1'b0, len_r[act]} + 15'd1))
        sd_buff_din = 8'hFF;
      else
        sd_buff_din = buf_q[int'(act)*8 +: 8];
    end
  end

  always_comb begin
    track_len = '0;
    for (int s = 0; s < NUM_SLOTS; s++) track_len[s*14 +: 14] = len_r[s];
  end

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        trk_cur[s] <= TRK_NONE;
        len_r[s]   <= '0;
        freq_q[s]  <= '0;
      end
      wgate_q    <= '0;
      dirty      <= '0;
      mount_pend <= '0;
      hinit      <= '0;
      rr         <= '0;
      act        <= '0;
      old_trk    <= '0;
      new_trk    <= '0;
      abort_r    <= 1'b0;
    end else begin
      hinit   <= '0;
      wgate_q <= wgate;
      for (int s = 0; s < NUM_SLOTS; s++) freq_q[s] <= freq[s*2 +: 2];

      if (state == ARB && pick_ok) begin
        act     <= pick;
        old_trk <= trk_cur[pick];
        new_trk <= trk_req[int'(pick)*7 +: 7];
        rr      <= (int'(pick) == NUM_SLOTS - 1) ? '0 : pick + 1'b1;
      end

      if (state == IDLE)                     abort_r <= 1'b0;
      else if (in_xfer && img_mounted[act])  abort_r <= 1'b1;

      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (!slot_busy[s]) begin
          if (head_we[s]) dirty[s] <= 1'b1;
          if (len_r[s] == 14'd0 && trk_cur[s] != TRK_NONE && (wgate[s] || head_we[s])) begin
            len_r[s] <= fmt_len[s];
            hinit[s] <= 1'b1;
            dirty[s] <= 1'b1;
          end else if (len_r[s] != 14'd0 && (wgate[s] || head_we[s]) &&
                       (freq[s*2 +: 2] != freq_q[s] || wgate[s] != wgate_q[s])) begin
            len_r[s] <= fmt_len[s];
          end
        end
        if (img_mounted[s]) begin
          mount_pend[s] <= 1'b1;
          dirty[s]      <= 1'b0;
        end
      end

      if (load_xfer && sd_buff_wr) begin
        case (sd_buff_addr)
          14'd0: len_r[act][7:0]  <= sd_buff_dout;
          14'd1: len_r[act][13:8] <= sd_buff_dout[5:0];
          14'd2: if (len_r[act] > LEN_MAX) len_r[act] <= LEN_MAX;
          default: ;
        endcase
      end

      if (state == LOAD_END && !abort_now) begin
        trk_cur[act]    <= new_trk;
        dirty[act]      <= 1'b0;
        mount_pend[act] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_c157x_track_mgr.sv
// Directed bench for c157x_track_mgr: loads, write-back, clamp, round robin,
// empty-track format, mount abort and reset during a transfer.
module tb_c157x_track_mgr;
  logic        sd_clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  img_mounted = '0;
  logic [6:0]  trk0 = 7'h7F, trk1 = 7'h7F;
  logic [13:0] trk_req;
  logic [3:0]  freq = 4'b1000;
  logic [1:0]  wgate = '0, head_we = '0;
  logic [1:0]  slot_busy, hinit, sd_rd, sd_wr, buf_sel;
  logic [27:0] track_len;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [13:0] sd_buff_addr = '0;
  logic [7:0]  sd_buff_dout = '0, sd_buff_din;
  logic [15:0] buf_q = '0;
  int pass_cnt = 0;
  int total = 0;
  bit ok;

  assign trk_req = {trk1, trk0};
  always #5 sd_clk = ~sd_clk;

  c157x_track_mgr dut (
    .sd_clk(sd_clk), .reset(reset), .img_mounted(img_mounted), .trk_req(trk_req),
    .freq(freq), .wgate(wgate), .head_we(head_we), .slot_busy(slot_busy), .hinit(hinit),
    .track_len(track_len), .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .buf_q(buf_q), .buf_sel(buf_sel)
  );

  task automatic step();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if ((sd_rd | sd_wr) != 2'b00) found = 1'b1;
      else step();
    end
  endtask

  // Entered in LOAD_REQ; returns with the FSM back in IDLE.
  task automatic serve_load(input logic [7:0] lo, input logic [7:0] hi);
    sd_ack = 1'b1; step();
    sd_buff_wr = 1'b1; sd_buff_addr = 14'd0; sd_buff_dout = lo; step();
    sd_buff_addr = 14'd1; sd_buff_dout = hi; step();
    sd_buff_addr = 14'd2; sd_buff_dout = 8'h00; step();
    sd_buff_wr = 1'b0; sd_ack = 1'b0; step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); step();
    total++; if (sd_blk_cnt !== 6'd0) $display("FAIL rst_blk_cnt: got %0d expected 0", sd_blk_cnt); else pass_cnt++;
    reset = 1'b0; step();
    total++; if (slot_busy !== 2'b00) $display("FAIL rst_busy: got %b expected 00", slot_busy); else pass_cnt++;
    total++; if (hinit !== 2'b00) $display("FAIL rst_hinit: got %b expected 00", hinit); else pass_cnt++;
    total++; if (track_len !== 28'd0) $display("FAIL rst_len: got %h expected 0", track_len); else pass_cnt++;
    total++; if ((sd_rd | sd_wr) !== 2'b00) $display("FAIL rst_req: got rd=%b wr=%b expected 00", sd_rd, sd_wr); else pass_cnt++;
    total++; if (sd_lba !== 32'd0 || buf_sel !== 2'b00) $display("FAIL rst_lba_sel: got lba=%0d sel=%b expected 0", sd_lba, buf_sel); else pass_cnt++;
  endtask

  task automatic test_load();
    trk0 = 7'd18;
    wait_req(ok);
    total++; if (!ok || sd_rd !== 2'b01) $display("FAIL load_rd: got %b expected 01", sd_rd); else pass_cnt++;
    total++; if (sd_lba !== 32'd576) $display("FAIL load_lba: got %0d expected 576", sd_lba); else pass_cnt++;
    total++; if (slot_busy !== 2'b01 || buf_sel !== 2'b01) $display("FAIL load_busy: got busy=%b sel=%b expected 01", slot_busy, buf_sel); else pass_cnt++;
    total++; if (sd_blk_cnt !== 6'd31) $display("FAIL blk_cnt: got %0d expected 31", sd_blk_cnt); else pass_cnt++;
    sd_ack = 1'b1; step();
    total++; if (sd_rd !== 2'b00) $display("FAIL load_rd_drop: got %b expected 00", sd_rd); else pass_cnt++;
    sd_buff_wr = 1'b1; sd_buff_addr = 14'd0; sd_buff_dout = 8'h1A; step();
    sd_buff_addr = 14'd1; step();
    sd_buff_addr = 14'd2; sd_buff_dout = 8'h00; step();
    sd_buff_wr = 1'b0;
    total++; if (track_len[13:0] !== 14'd6682) $display("FAIL load_len: got %0d expected 6682", track_len[13:0]); else pass_cnt++;
    sd_ack = 1'b0; step();
    total++; if (slot_busy !== 2'b01) $display("FAIL load_end_busy: got %b expected 01", slot_busy); else pass_cnt++;
    step();
    total++; if (slot_busy !== 2'b00) $display("FAIL load_idle_busy: got %b expected 00", slot_busy); else pass_cnt++;
  endtask

  task automatic test_flush();
    head_we = 2'b01; step(); head_we = 2'b00;
    trk0 = 7'd19;
    wait_req(ok);
    total++; if (!ok || sd_wr !== 2'b01 || sd_rd !== 2'b00) $display("FAIL flush_wr: got wr=%b rd=%b expected wr=01 rd=00", sd_wr, sd_rd); else pass_cnt++;
    total++; if (sd_lba !== 32'd576) $display("FAIL flush_lba: got %0d expected 576", sd_lba); else pass_cnt++;
    buf_q = 16'h00A5;
    sd_buff_addr = 14'd0; #1;
    total++; if (sd_buff_din !== 8'h1A) $display("FAIL hdr_lo: got %h expected 1a", sd_buff_din); else pass_cnt++;
    sd_buff_addr = 14'd1; #1;
    total++; if (sd_buff_din !== 8'h1A) $display("FAIL hdr_hi: got %h expected 1a", sd_buff_din); else pass_cnt++;
    sd_buff_addr = 14'd100; #1;
    total++; if (sd_buff_din !== 8'hA5) $display("FAIL din_data: got %h expected a5", sd_buff_din); else pass_cnt++;
    sd_buff_addr = 14'd6683; #1;
    total++; if (sd_buff_din !== 8'hA5) $display("FAIL din_last: got %h expected a5", sd_buff_din); else pass_cnt++;
    sd_buff_addr = 14'd6684; #1;
    total++; if (sd_buff_din !== 8'hFF) $display("FAIL din_pad: got %h expected ff", sd_buff_din); else pass_cnt++;
    sd_ack = 1'b1; step();
    sd_ack = 1'b0; step();
    step();
    wait_req(ok);
    total++; if (!ok || sd_rd !== 2'b01 || sd_lba !== 32'd608) $display("FAIL flush_reload: got rd=%b lba=%0d expected rd=01 lba=608", sd_rd, sd_lba); else pass_cnt++;
    serve_load(8'h00, 8'h10);
    total++; if (track_len[13:0] !== 14'd4096) $display("FAIL flush_newlen: got %0d expected 4096", track_len[13:0]); else pass_cnt++;
  endtask

  task automatic test_clamp();
    trk0 = 7'd20;
    wait_req(ok);
    total++; if (!ok || sd_rd !== 2'b01 || sd_lba !== 32'd640) $display("FAIL clamp_req: got rd=%b lba=%0d expected rd=01 lba=640", sd_rd, sd_lba); else pass_cnt++;
    sd_ack = 1'b1; step();
    sd_buff_wr = 1'b1; sd_buff_addr = 14'd0; sd_buff_dout = 8'hFF; step();
    sd_buff_addr = 14'd1; sd_buff_dout = 8'h3F; step();
    total++; if (track_len[13:0] !== 14'd16383) $display("FAIL clamp_raw: got %0d expected 16383", track_len[13:0]); else pass_cnt++;
    sd_buff_addr = 14'd2; sd_buff_dout = 8'h00; step();
    total++; if (track_len[13:0] !== 14'd16382) $display("FAIL clamp_len: got %0d expected 16382", track_len[13:0]); else pass_cnt++;
    sd_buff_wr = 1'b0; sd_ack = 1'b0; step(); step();
  endtask

  task automatic test_round_robin();
    trk0 = 7'h7F; trk1 = 7'h7F;
    reset = 1'b1; step(); step(); reset = 1'b0;
    trk0 = 7'd3; trk1 = 7'd5;
    wait_req(ok);
    total++; if (!ok || sd_rd !== 2'b01 || sd_lba !== 32'd96) $display("FAIL rr_first: got rd=%b lba=%0d expected rd=01 lba=96", sd_rd, sd_lba); else pass_cnt++;
    serve_load(8'h00, 8'h02);
    wait_req(ok);
    total++; if (!ok || sd_rd !== 2'b10 || sd_lba !== 32'd160) $display("FAIL rr_second: got rd=%b lba=%0d expected rd=10 lba=160", sd_rd, sd_lba); else pass_cnt++;
    serve_load(8'h00, 8'h02);
    trk0 = 7'd4; trk1 = 7'd6;
    wait_req(ok);
    total++; if (!ok || sd_rd !== 2'b01) $display("FAIL rr_wrap: got rd=%b expected 01", sd_rd); else pass_cnt++;
    serve_load(8'h00, 8'h02);
    wait_req(ok);
    total++; if (!ok || sd_rd !== 2'b10 || sd_lba !== 32'd192) $display("FAIL rr_fourth: got rd=%b lba=%0d expected rd=10 lba=192", sd_rd, sd_lba); else pass_cnt++;
    serve_load(8'h00, 8'h00);
    total++; if (track_len[27:14] !== 14'd0 || hinit !== 2'b00) $display("FAIL empty_len: got len=%0d hinit=%b expected 0", track_len[27:14], hinit); else pass_cnt++;
  endtask

  task automatic test_format();
    head_we = 2'b10; step(); head_we = 2'b00;
    total++; if (hinit !== 2'b10) $display("FAIL fmt_hinit: got %b expected 10", hinit); else pass_cnt++;
    total++; if (track_len[27:14] !== 14'd7142) $display("FAIL fmt_len: got %0d expected 7142", track_len[27:14]); else pass_cnt++;
    step();
    total++; if (hinit !== 2'b00) $display("FAIL fmt_hinit_once: got %b expected 00", hinit); else pass_cnt++;
    wgate = 2'b10; step();
    total++; if (track_len[27:14] !== 14'd12500 || hinit !== 2'b00) $display("FAIL fmt_mfm: got len=%0d hinit=%b expected 12500/00", track_len[27:14], hinit); else pass_cnt++;
    wgate = 2'b00; step();
  endtask

  task automatic test_mount_abort();
    trk1 = 7'd7;
    wait_req(ok);
    total++; if (!ok || sd_wr !== 2'b10 || sd_lba !== 32'd192) $display("FAIL mnt_flush: got wr=%b lba=%0d expected wr=10 lba=192", sd_wr, sd_lba); else pass_cnt++;
    sd_ack = 1'b1; step();
    img_mounted = 2'b10; step(); img_mounted = 2'b00;
    sd_ack = 1'b0; step();
    wait_req(ok);
    total++; if (!ok || sd_wr !== 2'b00 || sd_rd !== 2'b10) $display("FAIL mnt_reload: got wr=%b rd=%b expected wr=00 rd=10", sd_wr, sd_rd); else pass_cnt++;
    total++; if (sd_lba !== 32'd224) $display("FAIL mnt_lba: got %0d expected 224", sd_lba); else pass_cnt++;
    serve_load(8'h34, 8'h12);
    total++; if (track_len[27:14] !== 14'd4660 || slot_busy !== 2'b00) $display("FAIL mnt_len: got len=%0d busy=%b expected 4660/00", track_len[27:14], slot_busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    trk0 = 7'd9;
    wait_req(ok);
    total++; if (!ok || sd_rd !== 2'b01) $display("FAIL mid_req: got %b expected 01", sd_rd); else pass_cnt++;
    reset = 1'b1; #1;
    total++; if ((sd_rd | sd_wr) !== 2'b00) $display("FAIL mid_drop: got rd=%b wr=%b expected 00", sd_rd, sd_wr); else pass_cnt++;
    trk0 = 7'h7F; trk1 = 7'h7F;
    step(); reset = 1'b0;
    total++; if (slot_busy !== 2'b00 || track_len !== 28'd0) $display("FAIL mid_state: got busy=%b len=%h expected 0", slot_busy, track_len); else pass_cnt++;
    step();
    total++; if ((sd_rd | sd_wr) !== 2'b00) $display("FAIL mid_idle: got rd=%b wr=%b expected 00", sd_rd, sd_wr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_flush();
    test_clamp();
    test_round_robin();
    test_format();
    test_mount_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
